// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported word memory between the instruction-fetch port (I)
// and the load/store port (D). Each transaction walks IDLE -> ACCESS -> RESP,
// or IDLE -> RESP when the byte address is not word aligned (error response,
// no memory strobe).
//
// Configuration macro:
//   MEM_ARB_DPRIO_EN  defined   : D always wins a tie (fixed priority)
//                     undefined : round-robin, the port not granted last wins
//
// Ports:
//   clk, rst_n                : clock (rising edge), async active-low reset
//   i_req, i_addr             : fetch request and byte address
//   d_req, d_we, d_addr,
//   d_wdata                   : load/store request, direction, address, data
//   i_ack, d_ack              : one-cycle completion pulses
//   err                       : misaligned request flag, valid with an ack
//   rdata                     : read result, valid with an ack
//   mem_addr, mem_wdata,
//   mem_read, mem_write       : memory request, active only in ACCESS
//   mem_rdata                 : combinational memory read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          i_ack,
   output logic          d_ack,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_r;
   logic          gnt_d_r;       // 1: current transaction belongs to D
   logic          err_r;
   logic [DW-1:0] rdata_r;
`ifndef MEM_ARB_DPRIO_EN
   logic          last_gnt_d_r;  // 1: D was granted last
`endif

   logic          any_req_s;
   logic          win_d_s;
   logic [AW-1:0] win_addr_s;
   logic          win_we_s;
   logic [DW-1:0] win_wdata_s;
   logic          misaligned_s;

   // Winner selection and operand mux for the IDLE sampling edge.
   always_comb begin
      any_req_s = i_req | d_req;
`ifdef MEM_ARB_DPRIO_EN
      win_d_s = d_req;
`else
      if (i_req && d_req) begin
         win_d_s = ~last_gnt_d_r;
      end else begin
         win_d_s = d_req;
      end
`endif
      // Fetch is always a read, so D-side operands are masked for I grants.
      if (win_d_s) begin
         win_addr_s  = d_addr;
         win_we_s    = d_we;
         win_wdata_s = d_wdata;
      end else begin
         win_addr_s  = i_addr;
         win_we_s    = 1'b0;
         win_wdata_s = {DW{1'b0}};
      end
      misaligned_s = (win_addr_s[1:0] != 2'b00);
   end

   // Transaction FSM; all outputs are registers so they drop on reset at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         gnt_d_r      <= 1'b0;
         err_r        <= 1'b0;
         rdata_r      <= {DW{1'b0}};
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         mem_addr     <= {AW{1'b0}};
         mem_wdata    <= {DW{1'b0}};
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
`ifndef MEM_ARB_DPRIO_EN
         last_gnt_d_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  gnt_d_r      <= win_d_s;
`ifndef MEM_ARB_DPRIO_EN
                  last_gnt_d_r <= win_d_s;
`endif
                  if (misaligned_s) begin
                     // Error path skips memory and responds next cycle.
                     err_r   <= 1'b1;
                     rdata_r <= {DW{1'b0}};
                     i_ack   <= ~win_d_s;
                     d_ack   <= win_d_s;
                     state_r <= RESP;
                  end else begin
                     // The memory registers double as the latched operands.
                     mem_addr  <= win_addr_s;
                     mem_wdata <= win_wdata_s;
                     mem_write <= win_we_s;
                     mem_read  <= ~win_we_s;
                     state_r   <= ACCESS;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (mem_read) begin
                  rdata_r <= mem_rdata;
               end else begin
                  rdata_r <= {DW{1'b0}};
               end
               mem_addr  <= {AW{1'b0}};
               mem_wdata <= {DW{1'b0}};
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               i_ack     <= ~gnt_d_r;
               d_ack     <= gnt_d_r;
               state_r   <= RESP;
            end
            RESP: begin
               // Requests are deliberately not sampled on this edge.
               i_ack   <= 1'b0;
               d_ack   <= 1'b0;
               err_r   <= 1'b0;
               rdata_r <= {DW{1'b0}};
               state_r <= IDLE;
            end
            default: begin
               i_ack     <= 1'b0;
               d_ack     <= 1'b0;
               err_r     <= 1'b0;
               rdata_r   <= {DW{1'b0}};
               mem_addr  <= {AW{1'b0}};
               mem_wdata <= {DW{1'b0}};
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign err   = err_r;
   assign rdata = rdata_r;

endmodule
